// File: rtl/reg_handshake_sync_pkg.sv
// Shared constants and helpers for the reg_handshake_sync clock-domain crossing block.
package reg_handshake_sync_pkg;

    localparam int SYNC_STAGES_DEF   = 2;
    localparam int STABLE_CYCLES_DEF = 2;

    // Stability counter width: enough for 0..stable-1, never narrower than one bit.
    function automatic int cnt_width(input int stable);
        return (stable <= 2) ? 1 : $clog2(stable);
    endfunction

endpackage

// File: rtl/reg_handshake_sync_bit_sync_chain.sv
// Per-bit multi-flop synchronizer for a quasi-static bus entering the clk_out domain.
module bit_sync_chain #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic             clk_out,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [STAGES-1:0][WIDTH-1:0] s_q;
    logic [STAGES-1:0][WIDTH-1:0] s_d;

    always_comb begin
        s_d = {s_q[STAGES-2:0], din};
    end

    always_ff @(posedge clk_out or posedge rst) begin
        if (rst) begin
            s_q <= '0;
        end else begin
            s_q <= s_d;
        end
    end

    assign dout = s_q[STAGES-1];

endmodule

// File: rtl/reg_handshake_sync.sv
// Synchronizes an asynchronous register bus and only forwards values that held
// steady for STABLE_CYCLES consecutive synchronized samples.
module reg_handshake_sync
    import reg_handshake_sync_pkg::*;
#(
    parameter int WIDTH         = 8,
    parameter int SYNC_STAGES   = SYNC_STAGES_DEF,
    parameter int STABLE_CYCLES = STABLE_CYCLES_DEF
) (
    input  logic             clk_out,
    input  logic             rst,
    input  logic [WIDTH-1:0] reg_in,
    output logic [WIDTH-1:0] reg_out,
    output logic             update
);

    localparam int            CW      = cnt_width(STABLE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES - 1);

    logic [WIDTH-1:0] sv;
    logic [WIDTH-1:0] cand_q, cand_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] reg_out_q, reg_out_d;
    logic             update_q, update_d;

    bit_sync_chain #(
        .WIDTH  (WIDTH),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk_out (clk_out),
        .rst     (rst),
        .din     (reg_in),
        .dout    (sv)
    );

    always_comb begin
        cand_d    = cand_q;
        cnt_d     = cnt_q;
        reg_out_d = reg_out_q;
        update_d  = 1'b0;
        if (sv != cand_q) begin
            cand_d = sv;
            cnt_d  = '0;
        end else if (cnt_q < CNT_MAX) begin
            cnt_d = cnt_q + CW'(1);
        end else if (cand_q != reg_out_q) begin
            // Counter stays saturated, so a settled value commits exactly once.
            reg_out_d = cand_q;
            update_d  = 1'b1;
        end
    end

    always_ff @(posedge clk_out or posedge rst) begin
        if (rst) begin
            cand_q    <= '0;
            cnt_q     <= '0;
            reg_out_q <= '0;
            update_q  <= 1'b0;
        end else begin
            cand_q    <= cand_d;
            cnt_q     <= cnt_d;
            reg_out_q <= reg_out_d;
            update_q  <= update_d;
        end
    end

    assign reg_out = reg_out_q;
    assign update  = update_q;

endmodule

// File: tb/tb_reg_handshake_sync.sv
// Scoreboard bench for reg_handshake_sync: run-length reference model plus directed scenarios.
module tb_reg_handshake_sync;

    localparam int W   = 4;
    localparam int SS  = 2;
    localparam int SC  = 2;
    localparam int LAT = SS + SC + 1;

    logic         clk_out = 1'b0;
    logic         rst     = 1'b1;
    logic [W-1:0] reg_in  = '0;
    logic [W-1:0] reg_out;
    logic         update;

    reg_handshake_sync #(
        .WIDTH         (W),
        .SYNC_STAGES   (SS),
        .STABLE_CYCLES (SC)
    ) dut (
        .clk_out (clk_out),
        .rst     (rst),
        .reg_in  (reg_in),
        .reg_out (reg_out),
        .update  (update)
    );

    always #3 clk_out = ~clk_out;

    typedef struct {
        logic [W-1:0] val;
        int           edge_idx;
    } exp_t;

    exp_t          expq[$];
    int            n_tests = 0;
    int            n_fail  = 0;
    int            edge_no = 0;
    int            upd_count = 0;
    logic [15:0]   seen = '0;

    task automatic check(input string name, input int act, input int req);
        n_tests++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
        end
    endtask

    // Reference model: the value seen by the filter at edge k is the input
    // sampled SS edges earlier; a value commits once it has been seen on SC+1
    // consecutive edges and differs from what is already delivered.
    initial begin : model
        logic [W-1:0] hist [0:SS];
        logic [W-1:0] m_out, last_sv, sv;
        int run;
        forever begin
            @(posedge clk_out or posedge rst);
            if (rst) begin
                for (int j = 0; j <= SS; j++) hist[j] = '0;
                m_out   = '0;
                last_sv = '0;
                run     = 1;
                expq.delete();
            end else begin
                edge_no++;
                for (int j = SS; j > 0; j--) hist[j] = hist[j-1];
                hist[0] = reg_in;
                sv = hist[SS];
                if (sv == last_sv) run++;
                else run = 1;
                last_sv = sv;
                if (run >= SC + 1 && sv != m_out) begin
                    m_out = sv;
                    expq.push_back('{val: sv, edge_idx: edge_no});
                end
            end
        end
    end

    initial begin : monitor
        logic [W-1:0] prev_out;
        exp_t e;
        prev_out = '0;
        forever begin
            @(negedge clk_out);
            if (rst) begin
                check("reset_out", int'(reg_out), 0);
                check("reset_upd", int'(update), 0);
                prev_out = '0;
            end else begin
                if (update) begin
                    upd_count++;
                    if (expq.size() == 0) begin
                        check("spurious_update", 1, 0);
                    end else begin
                        e = expq.pop_front();
                        check("update_value", int'(reg_out), int'(e.val));
                        check("update_edge", edge_no, e.edge_idx);
                    end
                end else begin
                    check("hold_value", int'(reg_out), int'(prev_out));
                    if (expq.size() > 0 && expq[0].edge_idx <= edge_no) begin
                        e = expq.pop_front();
                        check("missing_update", 0, int'(e.val) + 1);
                    end
                end
                seen[reg_out] = 1'b1;
                prev_out = reg_out;
            end
        end
    end

    // Present a value cleanly and count edges until the update pulse appears.
    task automatic measure(input logic [W-1:0] val, input string name);
        int cnt;
        @(negedge clk_out);
        reg_in = val;
        cnt = 0;
        while (cnt <= 20) begin
            @(posedge clk_out);
            cnt++;
            @(negedge clk_out);
            if (update) break;
        end
        check(name, cnt, LAT);
        check({name, "_val"}, int'(reg_out), int'(val));
    endtask

    initial begin : stim
        int u0, n;
        logic [W-1:0] v;

        repeat (3) @(negedge clk_out);
        rst = 1'b0;
        repeat (6) @(negedge clk_out);
        check("idle_after_reset", int'(reg_out), 0);

        // Asynchronous reset assertion mid-cycle clears outputs immediately.
        measure(4'd5, "lat_first");
        @(posedge clk_out);
        #1;
        rst    = 1'b1;
        reg_in = '0;
        #1;
        check("async_rst_out", int'(reg_out), 0);
        check("async_rst_upd", int'(update), 0);
        @(negedge clk_out);
        rst = 1'b0;
        u0 = upd_count;
        repeat (10) @(negedge clk_out);
        check("post_rst_out", int'(reg_out), 0);
        check("post_rst_updates", upd_count - u0, 0);

        // Asynchronous 40 ns steps 1..5.
        @(negedge clk_out);
        u0 = upd_count;
        seen = '0;
        for (int i = 1; i <= 5; i++) begin
            reg_in = W'(i);
            #40;
        end
        repeat (8) @(negedge clk_out);
        check("seq_final", int'(reg_out), 5);
        check("seq_updates", upd_count - u0, 5);
        check("seq_seen", int'(seen), 16'h003F);

        // Glitch of two cycles is filtered out.
        measure(4'd0, "lat_zero");
        u0 = upd_count;
        @(negedge clk_out);
        reg_in = 4'd7;
        repeat (2) @(negedge clk_out);
        reg_in = 4'd0;
        repeat (10) @(negedge clk_out);
        check("glitch_out", int'(reg_out), 0);
        check("glitch_updates", upd_count - u0, 0);

        // Short intermediate value never appears.
        measure(4'd1, "lat_one");
        u0 = upd_count;
        seen = '0;
        @(negedge clk_out);
        reg_in = 4'd2;
        repeat (2) @(negedge clk_out);
        reg_in = 4'd3;
        repeat (10) @(negedge clk_out);
        check("rapid_out", int'(reg_out), 3);
        check("rapid_no_2", int'(seen[2]), 0);
        check("rapid_updates", upd_count - u0, 1);

        // Re-presenting the delivered value is silent.
        measure(4'd5, "lat_five");
        u0 = upd_count;
        @(negedge clk_out);
        reg_in = 4'd5;
        repeat (10) @(negedge clk_out);
        check("same_updates", upd_count - u0, 0);
        check("same_out", int'(reg_out), 5);

        // Reset three cycles into filtering restarts with full latency.
        @(negedge clk_out);
        reg_in = 4'd9;
        repeat (3) @(posedge clk_out);
        #1;
        rst = 1'b1;
        @(negedge clk_out);
        rst = 1'b0;
        n = 0;
        while (n <= 20) begin
            @(posedge clk_out);
            n++;
            @(negedge clk_out);
            if (update) break;
        end
        check("rst_mid_latency", n, LAT);
        check("rst_mid_val", int'(reg_out), 9);

        // Random values with random hold times, occasional resets.
        for (int i = 0; i < 300; i++) begin
            @(negedge clk_out);
            v = W'($urandom);
            reg_in = v;
            if ($urandom_range(0, 24) == 0) begin
                @(posedge clk_out);
                #1;
                rst = 1'b1;
                @(negedge clk_out);
                rst = 1'b0;
            end
            repeat ($urandom_range(0, 9)) @(negedge clk_out);
        end
        repeat (12) @(negedge clk_out);
        check("queue_empty", expq.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "timeout");
    end

endmodule
